dram_req_arbiter: RTL

// - Shares the single DRAMCON user-request port (D_REQ/D_INITADR/D_ELEM/D_BUSY) between NREQ requesters.

---
 rtl/dram_req_arbiter_pkg.sv | 16 +
 rtl/dram_req_arbiter_rr_pick.sv | 30 +++
 rtl/dram_req_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dram_req_arbiter_pkg.sv
// Shared request codes and helpers for the DRAMCON user-port arbiter.
package dram_req_arbiter_pkg;

   localparam logic [1:0] DRAM_REQ_NONE    = 2'b00;
   localparam logic [1:0] DRAM_REQ_READ    = 2'b01;
   localparam logic [1:0] DRAM_REQ_WRITE   = 2'b10;
   localparam logic [1:0] DRAM_REQ_ILLEGAL = 2'b11;

   localparam int APPADDR_WIDTH = 32;

   // A code takes part in arbitration only when it names a real transfer.
   function automatic logic is_valid_code(input logic [1:0] code);
      return (code == DRAM_REQ_READ) || (code == DRAM_REQ_WRITE);
   endfunction

endpackage

// File: rtl/dram_req_arbiter_rr_pick.sv
// Rotate-priority encoder: first valid requester at or after ptr, wrapping.
module rr_pick #(
   parameter int NREQ  = 2,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  valid,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Walk the requesters starting at ptr; the first valid one wins.
   always_comb begin
      int j;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      j      = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (!any && valid[j]) begin
            any       = 1'b1;
            onehot[j] = 1'b1;
            idx       = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/dram_req_arbiter.sv
// Shares the single DRAMCON user-request port between NREQ requesters.
// One transaction at a time: latch winner, pulse D_REQ, follow D_BUSY to completion.
module dram_req_arbiter
   import dram_req_arbiter_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int ADDR_W  = 32,
   parameter int BLK_W   = 32,
   parameter bit RR_MODE = 1'b1,
   parameter int ACK_TO  = 15
) (
   input  logic                     CLK,
   input  logic                     RST_X,
   input  logic [2*NREQ-1:0]        R_REQ,
   input  logic [ADDR_W*NREQ-1:0]   R_INITADR,
   input  logic [BLK_W*NREQ-1:0]    R_BLOCKS,
   output logic [NREQ-1:0]          R_ACK,
   output logic [NREQ-1:0]          R_DONE,
   output logic [NREQ-1:0]          GRANT,
   output logic [1:0]               D_REQ,
   output logic [31:0]              D_INITADR,
   output logic [31:0]              D_ELEM,
   input  logic                     D_BUSY,
   output logic                     ERR
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ISSUE    = 2'd1;
   localparam logic [1:0] ST_WAIT_ACK = 2'd2;
   localparam logic [1:0] ST_BUSY     = 2'd3;

   logic [1:0]        state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  win_idx;
   logic [1:0]        code_q;
   logic [ADDR_W-1:0] adr_q;
   logic [BLK_W-1:0]  blk_q;
   logic [3:0]        to_cnt;

   logic [NREQ-1:0]   req_valid;
   logic              any_illegal;
   logic [IDX_W-1:0]  pick_ptr;
   logic [NREQ-1:0]   pick_onehot;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;
   logic [1:0]        sel_code;
   logic [ADDR_W-1:0] sel_adr;
   logic [BLK_W-1:0]  sel_blk;

   // Classify each requester's code; 2'b11 is masked out and flagged.
   always_comb begin
      req_valid   = '0;
      any_illegal = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i] = is_valid_code(R_REQ[2*i +: 2]);
         if (R_REQ[2*i +: 2] == DRAM_REQ_ILLEGAL) begin
            any_illegal = 1'b1;
         end
      end
   end

   assign pick_ptr = RR_MODE ? rr_ptr : '0;

   rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_pick (
      .valid  (req_valid),
      .ptr    (pick_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // Select the winner's code, address and block count for latching.
   always_comb begin
      sel_code = DRAM_REQ_NONE;
      sel_adr  = '0;
      sel_blk  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_onehot[i]) begin
            sel_code = R_REQ[2*i +: 2];
            sel_adr  = R_INITADR[ADDR_W*i +: ADDR_W];
            sel_blk  = R_BLOCKS[BLK_W*i +: BLK_W];
         end
      end
   end

   // The address and length come straight from the latch registers, so they hold after issue.
   assign D_INITADR = 32'(adr_q);
   assign D_ELEM    = 32'(blk_q);

   // Transaction FSM with latch registers, ack timeout and sticky error.
   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         state   <= ST_IDLE;
         rr_ptr  <= '0;
         win_idx <= '0;
         code_q  <= DRAM_REQ_NONE;
         adr_q   <= '0;
         blk_q   <= '0;
         to_cnt  <= '0;
         R_ACK   <= '0;
         R_DONE  <= '0;
         GRANT   <= '0;
         D_REQ   <= DRAM_REQ_NONE;
         ERR     <= 1'b0;
      end else begin
         R_ACK  <= '0;
         R_DONE <= '0;
         D_REQ  <= DRAM_REQ_NONE;
         case (state)
            ST_IDLE: begin
               if (!D_BUSY) begin
                  if (any_illegal) begin
                     ERR <= 1'b1;
                  end
                  if (pick_any) begin
                     code_q  <= sel_code;
                     adr_q   <= sel_adr;
                     blk_q   <= sel_blk;
                     win_idx <= pick_idx;
                     GRANT   <= pick_onehot;
                     state   <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               D_REQ  <= code_q;
               R_ACK  <= GRANT;
               to_cnt <= '0;
               state  <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (D_BUSY) begin
                  state <= ST_BUSY;
               end else if (to_cnt == 4'(ACK_TO - 1)) begin
                  ERR    <= 1'b1;
                  R_DONE <= GRANT;
                  GRANT  <= '0;
                  to_cnt <= '0;
                  state  <= ST_IDLE;
               end else begin
                  to_cnt <= to_cnt + 4'd1;
               end
            end
            ST_BUSY: begin
               if (!D_BUSY) begin
                  R_DONE <= GRANT;
                  GRANT  <= '0;
                  if (RR_MODE) begin
                     rr_ptr <= (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
                  end
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
